writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Final pipeline stage of the 8-bit core: the writer side of the register-file write port that the decode
//   stage consumes. Captures one retiring instruction per cycle and selects its result (ALU, memory, immediate,
//   link). Holds the pipeline while a load's data is outstanding. Drives RegWrite/write_reg/write_data into decode.
// PARAMETERS
//   DATA_W       8    register/result width
//   MEM_TIMEOUT  16   max cycles spent in WAIT_MEM before the load is abandoned (>=2)
//   CNT_W        16   width of the retired-instruction counter
// PORTS
//   clk            in   1       clock; all state updates on rising edge
//   reset          in   1       synchronous, active-high reset
//   flush          in   1       cancel capture this cycle / abandon an outstanding load
//   in_valid       in   1       MEM stage presents an instruction
//   in_ready       out  1       stage accepts this cycle (combinational: state==IDLE)
//   in_reg_write   in   1       instruction writes rd
//   in_rd          in   3       destination register
//   in_result_src  in   2       00 ALU, 01 MEM (load, opcode 1001), 10 IMM (opcode 1010), 11 LINK
//   in_alu_result  in   DATA_W  ALU result
//   in_imm         in   DATA_W  sign-extended immediate
//   in_pc_next     in   DATA_W  PC+1 for link writes
//   mem_rvalid     in   1       load data valid (sampled only in WAIT_MEM)
//   mem_rdata      in   DATA_W  load data
//   RegWrite       out  1       register-file write enable (registered)
//   write_reg      out  3       register-file write address (registered)
//   write_data     out  DATA_W  register-file write data (registered)
//   wb_stall       out  1       stall request upstream (combinational: state==WAIT_MEM)
//   retire_count   out  CNT_W   instructions retired since reset
//   mem_timeout    out  1       sticky: a load was abandoned on timeout
// BEHAVIOUR
//   Reset: state=IDLE; RegWrite=0, write_reg=0, write_data=0, retire_count=0, mem_timeout=0, wait_cnt=0.
//   States: IDLE, WAIT_MEM (2-bit encoding, values 0/1).
//   Capture = in_valid & in_ready & ~flush. With flush=1 in IDLE the input is dropped as a bubble.
//   IDLE, capture, src!=MEM: next cycle RegWrite=in_reg_write, write_reg=in_rd, write_data=selected source;
//     retire_count+1. Latency 1 cycle. Back-to-back captures allowed every cycle.
//   IDLE, capture, src==MEM: latch rd/reg_write, wait_cnt=0, -> WAIT_MEM; next cycle RegWrite=0.
//   WAIT_MEM: in_ready=0, wb_stall=1, wait_cnt+1 per cycle.
//     mem_rvalid=1: next cycle RegWrite=latched reg_write, write_reg=latched rd, write_data=mem_rdata,
//       retire_count+1, -> IDLE. The first new capture happens in the cycle after the return to IDLE.
//     wait_cnt==MEM_TIMEOUT-1 and no rvalid: -> IDLE, mem_timeout=1, no write, no retire.
//     flush=1: -> IDLE, no write, no retire (flush beats rvalid and timeout).
//     rvalid on the timeout cycle: rvalid wins, normal write, mem_timeout unchanged.
//   RegWrite is 0 in every cycle with no write; it is a one-cycle pulse per write. write_reg/write_data hold
//     their last values when RegWrite=0. A write already registered is not cancelled by a later flush.
//   mem_rvalid in IDLE is ignored. r0 is not special-cased.
//   retire_count wraps from all-ones to 0. mem_timeout clears only on reset.
//   Reset mid-load: outstanding load discarded, no write, all registers to reset values.
// STRUCTURE
//   Shared header core_defs: RESULT_SRC_{ALU,MEM,IMM,LINK}, WB state encoding, NOP_INSTR=16'hE000.
//   Sub-module writeback_result_mux: combinational 4:1 select on in_result_src.
//   Top level: FSM, wait counter, output registers, retire counter.
// TESTING
//   ALU op: in_valid, reg_write=1, rd=3, src=00, alu=8'h5A -> next cycle RegWrite=1, write_reg=3,
//     write_data=8'h5A, retire_count=1.
//   Load: src=01, rd=2; rvalid=1 with rdata=8'hC3 on the 3rd WAIT_MEM cycle -> wb_stall=1 and in_ready=0 for
//     3 cycles, then RegWrite=1, write_reg=2, write_data=8'hC3.
//   Timeout: MEM_TIMEOUT=4, load with no rvalid -> IDLE after 4 cycles, mem_timeout=1, RegWrite never set,
//     retire_count unchanged.
//   Flush: flush during WAIT_MEM coinciding with rvalid -> no write, IDLE next cycle; flush with in_valid in
//     IDLE -> no write, no retire.
//   Sources/stream: 4 back-to-back captures with src=10 imm=8'hF0, src=11 pc_next=8'h21, src=00, and
//     reg_write=0 -> writes with data F0 then 21, then the ALU value, then RegWrite=0; retire_count=4.
//   Reset/wrap: preload retire_count to FFFF, retire once -> 0000; assert reset while in WAIT_MEM -> all
//     outputs zero next cycle.

Source files
------------

// File: rtl/core_defs.sv
// Shared definitions for the 8-bit core: result-source codes, writeback FSM
// encoding and the canonical NOP instruction word.
package core_defs;

    typedef enum logic [1:0] {
        RESULT_SRC_ALU  = 2'b00,
        RESULT_SRC_MEM  = 2'b01,
        RESULT_SRC_IMM  = 2'b10,
        RESULT_SRC_LINK = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1
    } wb_state_e;

    localparam logic [15:0] NOP_INSTR = 16'hE000;

endpackage

// File: rtl/writeback_result_mux.sv
// Combinational 4:1 selection of the writeback result by result source.
module writeback_result_mux
    import core_defs::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] link_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = alu_i;
        case (result_src_e'(sel_i))
            RESULT_SRC_ALU:  data_o = alu_i;
            RESULT_SRC_MEM:  data_o = mem_i;
            RESULT_SRC_IMM:  data_o = imm_i;
            RESULT_SRC_LINK: data_o = link_i;
            default:         data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction per cycle into the register-file
// write port, stalling upstream while a load's data is outstanding.
module writeback_stage
    import core_defs::*;
#(
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [2:0]        in_rd,
    input  logic [1:0]        in_result_src,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc_next,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              RegWrite,
    output logic [2:0]        write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              wb_stall,
    output logic [CNT_W-1:0]  retire_count,
    output logic              mem_timeout
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    wb_state_e         state_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic              ld_reg_write_q;
    logic [2:0]        ld_rd_q;
    logic              reg_write_q;
    logic [2:0]        write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic [CNT_W-1:0]  retire_q;
    logic              timeout_q;

    logic [DATA_W-1:0] sel_data_d;
    logic              capture_d;

    writeback_result_mux #(.DATA_W(DATA_W)) u_mux (
        .sel_i  (in_result_src),
        .alu_i  (in_alu_result),
        .mem_i  (mem_rdata),
        .imm_i  (in_imm),
        .link_i (in_pc_next),
        .data_o (sel_data_d)
    );

    assign in_ready  = (state_q == WB_IDLE);
    assign wb_stall  = (state_q == WB_WAIT_MEM);
    assign capture_d = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WB_IDLE;
            wait_cnt_q     <= '0;
            ld_reg_write_q <= 1'b0;
            ld_rd_q        <= '0;
            reg_write_q    <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            retire_q       <= '0;
            timeout_q      <= 1'b0;
        end else begin
            // RegWrite is a one-cycle pulse; data/address hold between writes.
            reg_write_q <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (capture_d) begin
                        if (result_src_e'(in_result_src) == RESULT_SRC_MEM) begin
                            ld_reg_write_q <= in_reg_write;
                            ld_rd_q        <= in_rd;
                            wait_cnt_q     <= '0;
                            state_q        <= WB_WAIT_MEM;
                        end else begin
                            reg_write_q <= in_reg_write;
                            if (in_reg_write) begin
                                write_reg_q  <= in_rd;
                                write_data_q <= sel_data_d;
                            end
                            retire_q <= retire_q + CNT_W'(1);
                        end
                    end
                end
                WB_WAIT_MEM: begin
                    wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                    // Priority: flush, then returning data, then timeout.
                    if (flush) begin
                        state_q <= WB_IDLE;
                    end else if (mem_rvalid) begin
                        reg_write_q <= ld_reg_write_q;
                        if (ld_reg_write_q) begin
                            write_reg_q  <= ld_rd_q;
                            write_data_q <= mem_rdata;
                        end
                        retire_q <= retire_q + CNT_W'(1);
                        state_q  <= WB_IDLE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= WB_IDLE;
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    assign RegWrite     = reg_write_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign retire_count = retire_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (MEM_TIMEOUT=4, CNT_W=16).
module tb_writeback_stage;

    localparam int DATA_W = 8;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_reg_write;
    logic [2:0]        in_rd;
    logic [1:0]        in_result_src;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_pc_next;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              RegWrite;
    logic [2:0]        write_reg;
    logic [DATA_W-1:0] write_data;
    logic              wb_stall;
    logic [CNT_W-1:0]  retire_count;
    logic              mem_timeout;

    int checks = 0;
    int errors = 0;

    writeback_stage #(.DATA_W(DATA_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_result_src (in_result_src),
        .in_alu_result (in_alu_result),
        .in_imm        (in_imm),
        .in_pc_next    (in_pc_next),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .RegWrite      (RegWrite),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .wb_stall      (wb_stall),
        .retire_count  (retire_count),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
        in_rd = 3'd0; in_result_src = 2'b00; in_alu_result = '0; in_imm = '0;
        in_pc_next = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_regwrite", 32'(RegWrite), 32'h0);
        chk("rst_wreg", 32'(write_reg), 32'h0);
        chk("rst_wdata", 32'(write_data), 32'h0);
        chk("rst_retire", 32'(retire_count), 32'h0);
        chk("rst_timeout", 32'(mem_timeout), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_stall", 32'(wb_stall), 32'h0);
        reset = 1'b0;

        // ALU write, one-cycle latency
        in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 3'd3; in_result_src = 2'b00; in_alu_result = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("alu_regwrite", 32'(RegWrite), 32'h1);
        chk("alu_wreg", 32'(write_reg), 32'h3);
        chk("alu_wdata", 32'(write_data), 32'h5A);
        chk("alu_retire", 32'(retire_count), 32'h1);
        step();
        chk("alu_pulse", 32'(RegWrite), 32'h0);
        chk("alu_hold", 32'(write_data), 32'h5A);

        // Load returning on the 3rd WAIT_MEM cycle
        in_valid = 1'b1; in_result_src = 2'b01; in_rd = 3'd2; in_reg_write = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ld_regwrite_c1", 32'(RegWrite), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("ld_stall_c%0d", c), 32'(wb_stall), 32'h1);
            chk($sformatf("ld_ready_c%0d", c), 32'(in_ready), 32'h0);
            if (c == 3) begin
                mem_rvalid = 1'b1; mem_rdata = 8'hC3;
            end
            step();
        end
        mem_rvalid = 1'b0;
        chk("ld_regwrite", 32'(RegWrite), 32'h1);
        chk("ld_wreg", 32'(write_reg), 32'h2);
        chk("ld_wdata", 32'(write_data), 32'hC3);
        chk("ld_retire", 32'(retire_count), 32'h2);
        chk("ld_ready", 32'(in_ready), 32'h1);
        chk("ld_stall_off", 32'(wb_stall), 32'h0);

        // Load timeout after MEM_TIMEOUT cycles in WAIT_MEM
        in_valid = 1'b1; in_result_src = 2'b01; in_rd = 3'd5;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= MEM_TIMEOUT; c++) begin
            chk($sformatf("to_stall_c%0d", c), 32'(wb_stall), 32'h1);
            chk($sformatf("to_nowrite_c%0d", c), 32'(RegWrite), 32'h0);
            chk($sformatf("to_flag_pre_c%0d", c), 32'(mem_timeout), 32'h0);
            step();
        end
        chk("to_ready", 32'(in_ready), 32'h1);
        chk("to_flag", 32'(mem_timeout), 32'h1);
        chk("to_regwrite", 32'(RegWrite), 32'h0);
        chk("to_retire", 32'(retire_count), 32'h2);
        chk("to_wdata", 32'(write_data), 32'hC3);

        // Flush in WAIT_MEM beats a coincident rvalid
        in_valid = 1'b1; in_result_src = 2'b01; in_rd = 3'd6;
        step();
        in_valid = 1'b0;
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'h77;
        step();
        flush = 1'b0; mem_rvalid = 1'b0;
        chk("fl_mem_regwrite", 32'(RegWrite), 32'h0);
        chk("fl_mem_ready", 32'(in_ready), 32'h1);
        chk("fl_mem_retire", 32'(retire_count), 32'h2);
        chk("fl_mem_wdata", 32'(write_data), 32'hC3);
        chk("fl_mem_flag", 32'(mem_timeout), 32'h1);

        // Flush with in_valid in IDLE drops the instruction
        in_valid = 1'b1; flush = 1'b1; in_result_src = 2'b00; in_rd = 3'd1; in_alu_result = 8'h11;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_regwrite", 32'(RegWrite), 32'h0);
        chk("fl_idle_retire", 32'(retire_count), 32'h2);
        chk("fl_idle_ready", 32'(in_ready), 32'h1);

        // rvalid in IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 8'h44;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_regwrite", 32'(RegWrite), 32'h0);
        chk("idle_rvalid_wdata", 32'(write_data), 32'hC3);

        // Back-to-back stream: IMM, LINK, ALU, no-write
        in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 3'd1; in_result_src = 2'b10; in_imm = 8'hF0;
        step();
        chk("st_imm_regwrite", 32'(RegWrite), 32'h1);
        chk("st_imm_wdata", 32'(write_data), 32'hF0);
        chk("st_imm_wreg", 32'(write_reg), 32'h1);
        in_result_src = 2'b11; in_pc_next = 8'h21; in_rd = 3'd4;
        step();
        chk("st_link_regwrite", 32'(RegWrite), 32'h1);
        chk("st_link_wdata", 32'(write_data), 32'h21);
        chk("st_link_wreg", 32'(write_reg), 32'h4);
        in_result_src = 2'b00; in_alu_result = 8'h3C; in_rd = 3'd7;
        step();
        chk("st_alu_regwrite", 32'(RegWrite), 32'h1);
        chk("st_alu_wdata", 32'(write_data), 32'h3C);
        chk("st_alu_wreg", 32'(write_reg), 32'h7);
        in_reg_write = 1'b0; in_rd = 3'd0; in_alu_result = 8'h99;
        step();
        in_valid = 1'b0;
        chk("st_nowr_regwrite", 32'(RegWrite), 32'h0);
        chk("st_nowr_wdata", 32'(write_data), 32'h3C);
        chk("st_nowr_wreg", 32'(write_reg), 32'h7);
        chk("st_retire", 32'(retire_count), 32'h6);

        // Drive the retire counter to all-ones, then wrap it
        in_valid = 1'b1; in_reg_write = 1'b0; in_result_src = 2'b00;
        repeat (32'hFFFF - 6) step();
        chk("wrap_full", 32'(retire_count), 32'hFFFF);
        step();
        in_valid = 1'b0;
        chk("wrap_zero", 32'(retire_count), 32'h0);

        // Reset while a load is outstanding
        in_valid = 1'b1; in_reg_write = 1'b1; in_result_src = 2'b01; in_rd = 3'd6;
        step();
        in_valid = 1'b0;
        chk("rl_stall", 32'(wb_stall), 32'h1);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 8'h55;
        step();
        reset = 1'b0; mem_rvalid = 1'b0;
        chk("rl_regwrite", 32'(RegWrite), 32'h0);
        chk("rl_wreg", 32'(write_reg), 32'h0);
        chk("rl_wdata", 32'(write_data), 32'h0);
        chk("rl_retire", 32'(retire_count), 32'h0);
        chk("rl_timeout", 32'(mem_timeout), 32'h0);
        chk("rl_stall_off", 32'(wb_stall), 32'h0);
        chk("rl_ready", 32'(in_ready), 32'h1);
        step();
        chk("rl_no_late_write", 32'(RegWrite), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
